cook_timer_ctrl: RTL and testbench
==================================

Name: cook_timer_ctrl

Overview:
- Sequencing controller for the microwave datapath. Owns cook time, countdown, run/pause/done state and magnetron enable.
- Inputs are the one-cycle pulses from the button debounce/spot front end, plus the BCD time on the switches.
- Drives the LED/SSD display path with the current state and a 4-digit BCD MM:SS value.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per one-second countdown tick. Must be >= 2.
- DONE_SECS, 3: number of ticks that `done` stays high before the block returns to IDLE.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: start or resume cooking
- stop  input  1  one-cycle pulse: pause, cancel or acknowledge
- add30  input  1  one-cycle pulse: add 30 s to the cook time
- load  input  1  one-cycle pulse: load `sw_time` as the cook time
- sw_time  input  16  BCD MMSS: [15:12] minute tens, [11:8] minute units, [7:4] second tens, [3:0] second units
- magnetron  output  1  high only in COOK
- done  output  1  high in DONE
- load_err  output  1  one-cycle pulse when a `load` is rejected
- state_o  output  3  IDLE=0, COOK=1, PAUSE=2, DONE=3
- time_bcd  output  16  current remaining time, BCD MMSS

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values: state IDLE, `time_bcd`=16'h0000, `magnetron`=0, `done`=0, `load_err`=0, prescaler=0, done counter=0.
- Outputs are registered. A state change or time change is visible on the cycle after the input pulse.
- Prescaler:
  - Runs only in COOK and DONE; counts 0..TICK_DIV-1.
  - `tick` is asserted on the cycle the count equals TICK_DIV-1, and the count then wraps to 0.
  - The prescaler clears to 0 on every entry into COOK or DONE, so the first tick occurs exactly TICK_DIV cycles after entry.
- IDLE:
  - `load`: if `sw_time` is valid BCD (every nibble <=9 and the second tens nibble <=5), then `time_bcd`<=`sw_time`. Otherwise `time_bcd` is unchanged and `load_err` pulses for one cycle.
  - `add30`: adds 30 s to `time_bcd`.
  - `start` with `time_bcd`!=0: go to COOK.
  - `start` with `time_bcd`==0: quick start; `time_bcd`<=0030 and go to COOK.
  - `stop`: `time_bcd`<=0000.
- COOK:
  - On each tick, decrement by 1 s in BCD. SS=00 borrows 1 minute and becomes 59.
  - Decrement to 0000 goes to DONE.
  - `stop` goes to PAUSE, and the time is held.
  - `add30` adds 30 s.
  - `start` and `load` are ignored.
- PAUSE:
  - `start` goes to COOK (prescaler cleared).
  - `stop` goes to IDLE with `time_bcd`<=0000.
  - `add30` adds 30 s.
  - `load` is ignored.
- DONE:
  - `done`=1 and `time_bcd`=0000.
  - After DONE_SECS ticks, go to IDLE.
  - `stop` goes to IDLE immediately.
  - All other inputs are ignored.
- add30 arithmetic:
  - Performed in BCD with carry from seconds (>=60) into minutes.
  - The result saturates at 9959 and never wraps.
- Simultaneous events:
  - Priority in all states is stop > start > load > add30.
  - In COOK, tick and add30 in the same cycle: result = sat(dec(t)+30). If dec(t)==0, the block stays in COOK with 0030.
  - In COOK, tick and stop in the same cycle: go to PAUSE, holding dec(t). If dec(t)==0, go to IDLE with 0000 instead.
- Reset mid-operation: returns to IDLE with 0000 on the next edge, regardless of state or pending pulses.

Optional Feature:
- Macro: DOOR_INTERLOCK_EN.
- When defined:
  - Extra port `door_open`, input, 1 bit, level signal.
  - `door_open`=1 in COOK forces PAUSE on the next edge.
  - `start` is ignored while `door_open`=1 in IDLE and PAUSE.
  - `magnetron` = (state==COOK) & ~`door_open`, so it drops combinationally the same cycle the door opens.
- When undefined: no `door_open` port, and `magnetron` is purely registered.

Test Plan:
- Load and run (TICK_DIV=4): `load` with `sw_time`=0102, then `start` -> COOK, `magnetron`=1; after 4 cycles `time_bcd`=0101; after 12 more cycles `time_bcd`=0058 (borrow).
- Load validation: `load` with 0170 or 01A0 -> `load_err` high for exactly 1 cycle, `time_bcd` unchanged; `load` with 0959 is accepted.
- Countdown to done: `load` 0002, `start` -> DONE after 8 cycles with `done`=1, `magnetron`=0; IDLE after 3x4 more cycles (DONE_SECS=3); `stop` in DONE -> IDLE on the next edge.
- add30 arithmetic: `add30` from 0045 -> 0115; from 9945 -> 9959 (saturated); `start` from 0000 -> 0030 and COOK.
- Pause and collisions: `stop` in COOK -> PAUSE with time held; `start` -> COOK with the next tick a full 4 cycles later; same-cycle tick+`add30` at 0001 -> COOK 0030; same-cycle `stop`+`start` in PAUSE -> IDLE 0000.
- Reset and interlock: `reset` mid-COOK -> IDLE, 0000, all outputs 0. With DOOR_INTERLOCK_EN: `door_open`=1 in COOK -> `magnetron`=0 the same cycle and PAUSE next; `start` is ignored while the door is open.

Source files
------------

// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl: microwave cook-time sequencer (IDLE/COOK/PAUSE/DONE).
// Owns the BCD MM:SS cook time, the one-second countdown, the done hold and
// the magnetron enable.
// Optional build macro DOOR_INTERLOCK_EN adds a door_open level input. While
// the door is open, COOK is forced to PAUSE, start is blocked, and magnetron
// is gated off combinationally.
module cook_timer_ctrl #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned DONE_SECS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        add30,
    input  logic        load,
    input  logic [15:0] sw_time,
`ifdef DOOR_INTERLOCK_EN
    input  logic        door_open,
`endif
    output logic        magnetron,
    output logic        done,
    output logic        load_err,
    output logic [2:0]  state_o,
    output logic [15:0] time_bcd
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DONE_SECS > 1) ? $clog2(DONE_SECS + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COOK  = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    time_q, time_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [DW-1:0]  dcnt_q, dcnt_d;
    logic           load_err_q, load_err_d;
    logic           done_q;
    logic           tick;
    logic           start_ok;
    logic           door;
    logic [15:0]    t_now;

    // BCD MMSS minus one second; SS=00 borrows a minute and becomes 59.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t == 16'h0000) begin
            r = t;
        end else if (t[3:0] != 4'd0) begin
            r[3:0] = t[3:0] - 4'd1;
        end else if (t[7:4] != 4'd0) begin
            r[7:4] = t[7:4] - 4'd1;
            r[3:0] = 4'd9;
        end else begin
            r[7:0] = 8'h59;
            if (t[11:8] != 4'd0) begin
                r[11:8] = t[11:8] - 4'd1;
            end else begin
                r[11:8]  = 4'd9;
                r[15:12] = t[15:12] - 4'd1;
            end
        end
        return r;
    endfunction

    // BCD MMSS plus 30 s, saturating at 99:59. Only the seconds tens digit
    // moves, and it carries into the minutes once it reaches 6.
    function automatic logic [15:0] bcd_add30(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[7:4] >= 4'd3) begin
            r[7:4] = t[7:4] - 4'd3;
            if (t[15:8] == 8'h99) begin
                r = 16'h9959;
            end else if (t[11:8] == 4'd9) begin
                r[11:8]  = 4'd0;
                r[15:12] = t[15:12] + 4'd1;
            end else begin
                r[11:8] = t[11:8] + 4'd1;
            end
        end else begin
            r[7:4] = t[7:4] + 4'd3;
        end
        return r;
    endfunction

    // Valid MMSS: every digit is 0..9 and the seconds tens digit is 0..5.
    function automatic logic bcd_valid(input logic [15:0] t);
        return (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
               (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
    endfunction

`ifdef DOOR_INTERLOCK_EN
    assign door = door_open;
`else
    assign door = 1'b0;
`endif

    assign tick     = ((state_q == COOK) || (state_q == DONE)) &&
                      (presc_q == PW'(TICK_DIV - 1));
    assign start_ok = start & ~door;

    // Next-state, next-time and counter logic.
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        load_err_d = 1'b0;
        presc_d    = '0;
        dcnt_d     = '0;
        t_now      = tick ? bcd_dec(time_q) : time_q;
        case (state_q)
            IDLE: begin
                if (stop) begin
                    time_d = 16'h0000;
                end else if (start_ok) begin
                    state_d = COOK;
                    if (time_q == 16'h0000) begin
                        time_d = 16'h0030;
                    end
                end else if (load) begin
                    if (bcd_valid(sw_time)) begin
                        time_d = sw_time;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (add30) begin
                    time_d = bcd_add30(time_q);
                end
            end
            COOK: begin
                if (stop) begin
                    if (t_now == 16'h0000) begin
                        state_d = IDLE;
                        time_d  = 16'h0000;
                    end else begin
                        state_d = PAUSE;
                        time_d  = t_now;
                    end
                end else if (door) begin
                    time_d  = t_now;
                    state_d = (t_now == 16'h0000) ? DONE : PAUSE;
                end else if (add30) begin
                    time_d = bcd_add30(t_now);
                end else begin
                    time_d = t_now;
                    if (t_now == 16'h0000) begin
                        state_d = DONE;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = IDLE;
                    time_d  = 16'h0000;
                end else if (start_ok) begin
                    state_d = COOK;
                end else if (add30) begin
                    time_d = bcd_add30(time_q);
                end
            end
            DONE: begin
                time_d = 16'h0000;
                if (stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (dcnt_q == DW'(DONE_SECS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end else begin
                    dcnt_d = dcnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                time_d  = 16'h0000;
            end
        endcase

        // Prescaler restarts from 0 on every state change and free-runs in COOK/DONE.
        if (state_d != state_q) begin
            presc_d = '0;
        end else if ((state_q == COOK) || (state_q == DONE)) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // State, time, counters and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            time_q     <= 16'h0000;
            presc_q    <= '0;
            dcnt_q     <= '0;
            load_err_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            dcnt_q     <= dcnt_d;
            load_err_q <= load_err_d;
            done_q     <= (state_d == DONE);
        end
    end

`ifdef DOOR_INTERLOCK_EN
    // Magnetron drops in the same cycle the door opens.
    assign magnetron = (state_q == COOK) & ~door_open;
`else
    logic magnetron_q;

    // Registered magnetron enable, high only while in COOK.
    always_ff @(posedge clk) begin
        if (reset) begin
            magnetron_q <= 1'b0;
        end else begin
            magnetron_q <= (state_d == COOK);
        end
    end

    assign magnetron = magnetron_q;
`endif

    assign done     = done_q;
    assign load_err = load_err_q;
    assign state_o  = state_q;
    assign time_bcd = time_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed self-checking bench for cook_timer_ctrl with TICK_DIV=4, DONE_SECS=3.
module tb_cook_timer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, add30, load;
    logic [15:0] sw_time;
    logic        magnetron, done, load_err;
    logic [2:0]  state_o;
    logic [15:0] time_bcd;
`ifdef DOOR_INTERLOCK_EN
    logic        door_open;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [15:0] S_IDLE  = 16'd0;
    localparam logic [15:0] S_COOK  = 16'd1;
    localparam logic [15:0] S_PAUSE = 16'd2;
    localparam logic [15:0] S_DONE  = 16'd3;

    cook_timer_ctrl #(.TICK_DIV(4), .DONE_SECS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .add30     (add30),
        .load      (load),
        .sw_time   (sw_time),
`ifdef DOOR_INTERLOCK_EN
        .door_open (door_open),
`endif
        .magnetron (magnetron),
        .done      (done),
        .load_err  (load_err),
        .state_o   (state_o),
        .time_bcd  (time_bcd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic p_start, input logic p_stop,
                         input logic p_add30, input logic p_load);
        start = p_start; stop = p_stop; add30 = p_add30; load = p_load;
        step(1);
        start = 1'b0; stop = 1'b0; add30 = 1'b0; load = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        sw_time = v;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; add30 = 1'b0; load = 1'b0;
        sw_time = 16'h0000;
`ifdef DOOR_INTERLOCK_EN
        door_open = 1'b0;
`endif
        step(2);
        reset = 1'b0;
        check("rst_state", 16'(state_o), S_IDLE);
        check("rst_time", time_bcd, 16'h0000);
        check("rst_mag", 16'(magnetron), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_lerr", 16'(load_err), 16'd0);

        // Load and run with a minute borrow.
        do_load(16'h0102);
        check("load_0102", time_bcd, 16'h0102);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("run_state", 16'(state_o), S_COOK);
        check("run_mag", 16'(magnetron), 16'd1);
        step(4);
        check("tick1", time_bcd, 16'h0101);
        step(12);
        check("borrow", time_bcd, 16'h0058);

        // Pause, resume with a full tick period, then stop+start in PAUSE.
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("pause_state", 16'(state_o), S_PAUSE);
        check("pause_time", time_bcd, 16'h0058);
        check("pause_mag", 16'(magnetron), 16'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("resume_state", 16'(state_o), S_COOK);
        step(3);
        check("resume_no_tick", time_bcd, 16'h0058);
        step(1);
        check("resume_tick", time_bcd, 16'h0057);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("pause2_state", 16'(state_o), S_PAUSE);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check("stopstart_state", 16'(state_o), S_IDLE);
        check("stopstart_time", time_bcd, 16'h0000);

        // Load validation.
        do_load(16'h0170);
        check("bad_sec_err", 16'(load_err), 16'd1);
        check("bad_sec_time", time_bcd, 16'h0000);
        step(1);
        check("err_one_cycle", 16'(load_err), 16'd0);
        do_load(16'h01A0);
        check("bad_nib_err", 16'(load_err), 16'd1);
        do_load(16'h0959);
        check("good_err", 16'(load_err), 16'd0);
        check("good_time", time_bcd, 16'h0959);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_stop_clr", time_bcd, 16'h0000);

        // Countdown to DONE and hold for DONE_SECS ticks.
        do_load(16'h0002);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(7);
        check("cd_state7", 16'(state_o), S_COOK);
        check("cd_time7", time_bcd, 16'h0001);
        step(1);
        check("done_state", 16'(state_o), S_DONE);
        check("done_flag", 16'(done), 16'd1);
        check("done_mag", 16'(magnetron), 16'd0);
        check("done_time", time_bcd, 16'h0000);
        step(11);
        check("done_hold", 16'(state_o), S_DONE);
        step(1);
        check("done_exit", 16'(state_o), S_IDLE);
        check("done_exit_flag", 16'(done), 16'd0);

        // Tick and stop together with the countdown reaching zero.
        do_load(16'h0001);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(3);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("tickstop0_state", 16'(state_o), S_IDLE);
        check("tickstop0_time", time_bcd, 16'h0000);

        // Stop while in DONE.
        do_load(16'h0001);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(4);
        check("done2_state", 16'(state_o), S_DONE);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("done_stop", 16'(state_o), S_IDLE);

        // add30 arithmetic and quick start.
        do_load(16'h0045);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("add30_carry", time_bcd, 16'h0115);
        do_load(16'h9945);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("add30_sat", time_bcd, 16'h9959);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("add30_sat2", time_bcd, 16'h9959);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("quick_time", time_bcd, 16'h0030);
        check("quick_state", 16'(state_o), S_COOK);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);

        // Tick and add30 together at 0001.
        do_load(16'h0002);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        step(4);
        check("col_pre", time_bcd, 16'h0001);
        step(3);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("col_time", time_bcd, 16'h0030);
        check("col_state", 16'(state_o), S_COOK);

        // Reset mid-COOK.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mid_rst_state", 16'(state_o), S_IDLE);
        check("mid_rst_time", time_bcd, 16'h0000);
        check("mid_rst_mag", 16'(magnetron), 16'd0);
        check("mid_rst_done", 16'(done), 16'd0);

`ifdef DOOR_INTERLOCK_EN
        // Door interlock.
        do_load(16'h0005);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("door_cook_mag", 16'(magnetron), 16'd1);
        door_open = 1'b1;
        #1;
        check("door_mag_now", 16'(magnetron), 16'd0);
        step(1);
        check("door_pause", 16'(state_o), S_PAUSE);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("door_start_blk", 16'(state_o), S_PAUSE);
        door_open = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("door_resume", 16'(state_o), S_COOK);
        check("door_resume_mag", 16'(magnetron), 16'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
